arbiter_client_req: RTL and testbench

//  Client-side companion to the round-robin arbiter: one instance per arbiter client.

---
 rtl/arbiter_client_req.sv | 144 ++++++++++++++
 tb/tb_arbiter_client_req.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_client_req.sv
// arbiter_client_req: per-client request FIFO feeding a round-robin arbiter.
// Define ARB_REQ_TIMEOUT_EN to enable the starvation monitor (o_starve).
module arbiter_client_req #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    output logic                         o_req,
    input  logic                         i_gnt,
    output logic                         o_data_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_spurious_gnt,
    output logic                         o_starve
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_POP  = 2'd2
    } state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_spurious;
    state_t                r_state;

    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_count_nxt;

    assign o_wr_ready = (r_count != CW'(DEPTH));
    assign w_push     = i_wr_valid & o_wr_ready;
    assign w_pop      = i_gnt & (r_count != '0);

    // Greater-than rather than a raw subtraction: a spurious grant on an empty
    // queue must not wrap the difference and raise req.
    assign o_req = (r_count > CW'(i_gnt));

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // NOTE: the storage array is deliberately left out of reset; o_count alone
    // says which entries are live, so stale contents are never observed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // NOTE: every sequential block below uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data     <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_spurious <= i_gnt & (r_count == '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_data   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_push) r_state <= S_REQ;
                S_REQ:  if (w_pop)  r_state <= S_POP;
                S_POP: begin
                    if (w_pop) begin
                        r_state <= S_POP;
                    end else if (w_count_nxt != '0) begin
                        r_state <= S_REQ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_data_valid   = (r_state == S_POP);
    assign o_data         = r_data;
    assign o_count        = r_count;
    assign o_spurious_gnt = r_spurious;

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [TW-1:0] r_wait;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait <= '0;
        end else if (i_gnt || !o_req) begin
            r_wait <= '0;
        end else if (r_wait != TMAX) begin
            r_wait <= r_wait + TW'(1);
        end
    end

    assign o_starve = (r_wait == TMAX);
`else
    assign o_starve = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_client_req.sv
// Self-checking bench for arbiter_client_req: queue-based reference model with a
// per-cycle compare, directed literal checks, and a 3-client round-robin system test.
module tb_arbiter_client_req;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
`ifdef ARB_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          gnt = 1'b0;
    logic          wr_ready, req, data_valid, spurious, starve;
    logic [DW-1:0] data;
    logic [2:0]    count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arbiter_client_req #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_data(wr_data), .o_req(req), .i_gnt(gnt), .o_data_valid(data_valid),
        .o_data(data), .o_count(count), .o_spurious_gnt(spurious), .o_starve(starve)
    );

    // ---------------- 3-client system with a behavioural round-robin arbiter
    logic          c_wr_valid [3];
    logic [DW-1:0] c_wr_data  [3];
    logic [DW-1:0] c_data     [3];
    logic [2:0]    c_count    [3];
    logic [2:0]    c_gnt;
    logic [2:0]    c_req, c_dv, c_spur, c_rdy, c_starve;
    logic          arb_en = 1'b0;

    for (genvar c = 0; c < 3; c++) begin : g_cl
        arbiter_client_req #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) u_cl (
            .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(c_wr_valid[c]), .o_wr_ready(c_rdy[c]),
            .i_wr_data(c_wr_data[c]), .o_req(c_req[c]), .i_gnt(c_gnt[c]),
            .o_data_valid(c_dv[c]), .o_data(c_data[c]), .o_count(c_count[c]),
            .o_spurious_gnt(c_spur[c]), .o_starve(c_starve[c])
        );
    end

    int         arb_last;
    int         arb_next;
    int         arb_idx;
    logic [2:0] arb_pick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_gnt    <= '0;
            arb_last <= 2;
        end else begin
            arb_pick = '0;
            arb_next = arb_last;
            for (int k = 1; k <= 3; k++) begin
                arb_idx = (arb_last + k) % 3;
                if (arb_en && c_req[arb_idx] && arb_pick == '0) begin
                    arb_pick[arb_idx] = 1'b1;
                    arb_next = arb_idx;
                end
            end
            c_gnt    <= arb_pick;
            arb_last <= arb_next;
        end
    end

    logic [DW-1:0] got [$];
    int            spur_cnt = 0;

    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (c_dv[c]) got.push_back(c_data[c]);
        end
        if (c_spur != '0) spur_cnt++;
    end

    // ---------------- checking helpers
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: queue of pending payloads
    logic [DW-1:0] mq [$];
    logic [DW-1:0] m_data  = '0;
    logic          m_valid = 1'b0;
    logic          m_spur  = 1'b0;
    int            m_wait  = 0;
    int            m_size;
    bit            m_req;

    // Inputs change only just after posedge, so at negedge they already hold the
    // values the next posedge will sample: compare first, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_spur  = 1'b0;
            m_wait  = 0;
        end else begin
            m_size = mq.size();
            check("m_wr_ready", wr_ready, m_size < DEPTH);
            check("m_req", req, m_size > (gnt ? 1 : 0));
            check("m_count", count, m_size);
            check("m_data_valid", data_valid, m_valid);
            check("m_data", data, m_data);
            check("m_spurious", spurious, m_spur);
            check("m_starve", starve, TO_EN && (m_wait == TO));

            m_req = (m_size > (gnt ? 1 : 0));
            if (gnt || !m_req) m_wait = 0;
            else if (m_wait < TO) m_wait++;
            m_spur  = gnt && (m_size == 0);
            m_valid = gnt && (m_size != 0);
            if (m_valid) m_data = mq.pop_front();
            if (wr_valid && m_size < DEPTH) mq.push_back(wr_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 3; c++) begin
            c_wr_valid[c] = 1'b0;
            c_wr_data[c]  = '0;
        end

        // Reset state
        #3;
        check("rst_count", count, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_req", req, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_data", data, 0);
        check("rst_spurious", spurious, 0);
        check("rst_starve", starve, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1. single entry, grant one cycle after req
        wr_valid = 1'b1; wr_data = 32'hA5;
        tick();
        wr_valid = 1'b0;
        check("t1_count1", count, 1);
        check("t1_req_high", req, 1);
        gnt = 1'b1;
        #1;
        check("t1_req_drops_in_gnt", req, 0);
        tick();
        gnt = 1'b0;
        check("t1_dv", data_valid, 1);
        check("t1_data", data, 32'hA5);
        check("t1_count0", count, 0);
        tick();
        check("t1_dv_low", data_valid, 0);
        check("t1_data_hold", data, 32'hA5);

        // 2. fill, drop write while full, drain in order
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1; wr_data = DW'(i);
            tick();
        end
        wr_data = 32'h5;
        check("t2_full_not_ready", wr_ready, 0);
        tick();
        wr_valid = 1'b0;
        check("t2_count_full", count, 4);
        gnt = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t2_dv", data_valid, 1);
            check("t2_data_order", data, DW'(i));
        end
        gnt = 1'b0;
        check("t2_count_empty", count, 0);
        tick();

        // 3. full with simultaneous write and grant
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1; wr_data = DW'(32'h10 + i);
            tick();
        end
        wr_data = 32'h15; gnt = 1'b1;
        check("t3_not_ready", wr_ready, 0);
        tick();
        gnt = 1'b0;
        check("t3_count3", count, 3);
        check("t3_pop_data", data, 32'h11);
        check("t3_ready_again", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        check("t3_count4", count, 4);
        gnt = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("t3_drain", data, DW'(32'h10 + i));
        end
        gnt = 1'b0;
        tick();

        // 4. spurious grant on empty FIFO
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check("t4_spurious", spurious, 1);
        check("t4_no_dv", data_valid, 0);
        check("t4_count", count, 0);
        tick();
        check("t4_spurious_pulse", spurious, 0);

        // 6a. starvation monitor with one waiting entry
        wr_valid = 1'b1; wr_data = 32'h77;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("t6_starve_before", starve, 0);
        tick();
        check("t6_starve_set", starve, TO_EN);
        gnt = 1'b1;
        #1;
        check("t6_starve_held", starve, TO_EN);
        tick();
        gnt = 1'b0;
        check("t6_starve_clear", starve, 0);
        check("t6_data", data, 32'h77);
        tick();

        // 6b. asynchronous reset mid-FIFO
        for (int i = 1; i <= 3; i++) begin
            wr_valid = 1'b1; wr_data = DW'(32'hB0 + i);
            tick();
        end
        wr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_req", req, 0);
        check("ar_wr_ready", wr_ready, 1);
        check("ar_data_valid", data_valid, 0);
        check("ar_data", data, 0);
        check("ar_spurious", spurious, 0);
        check("ar_starve", starve, 0);
        tick();
        rst_n = 1'b1;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check("ar_gnt_spurious", spurious, 1);
        check("ar_gnt_no_dv", data_valid, 0);
        tick();

        // 5. three clients, two entries each, round-robin arbiter
        for (int k = 1; k <= 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                c_wr_valid[c] = 1'b1;
                c_wr_data[c]  = DW'(32'h100 * (c + 1) + k);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) c_wr_valid[c] = 1'b0;
        got.delete();
        spur_cnt = 0;
        arb_en = 1'b1;
        for (int i = 0; i < 40 && got.size() < 6; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        arb_en = 1'b0;
        check("t5_grant_total", got.size(), 6);
        if (got.size() == 6) begin
            check("t5_g0", got[0], 32'h101);
            check("t5_g1", got[1], 32'h201);
            check("t5_g2", got[2], 32'h301);
            check("t5_g3", got[3], 32'h102);
            check("t5_g4", got[4], 32'h202);
            check("t5_g5", got[5], 32'h302);
        end
        check("t5_spurious", spur_cnt, 0);
        for (int c = 0; c < 3; c++) check("t5_empty", c_count[c], 0);
        check("t5_req_idle", c_req, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
